// File: rtl/hazard3_ahb_pkg.sv
// Shared AHB5-Lite encodings and the data-phase owner state used by the
// two-master arbiter and its request buffers.
package hazard3_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    OWNER_IDLE = 2'd0,
    OWNER_D    = 2'd1,
    OWNER_I    = 2'd2
  } owner_t;

  // A SEQ is only a legal continuation if the previous downstream address
  // phase belonged to the same master; otherwise it must restart as NONSEQ.
  function automatic logic [1:0] seq_fixup(input logic [1:0] trans, input logic same_src);
    return (trans == HTRANS_SEQ && !same_src) ? HTRANS_NONSEQ : trans;
  endfunction

endpackage

// File: rtl/ahbl_req_buf.sv
// One-entry holding register for an AHB address phase that lost arbitration
// or arrived during a downstream wait state.
module ahbl_req_buf
  import hazard3_ahb_pkg::*;
#(
  parameter int W_ADDR = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [W_ADDR-1:0] haddr,
  input  logic              hwrite,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic [3:0]        hprot,
  output logic              full,
  output logic [W_ADDR-1:0] buf_haddr,
  output logic              buf_hwrite,
  output logic [1:0]        buf_htrans,
  output logic [2:0]        buf_hsize,
  output logic [3:0]        buf_hprot
);

  // Load and clear are never asserted together by the arbiter: a port's
  // request is only loaded while its buffer is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      full       <= 1'b0;
      buf_haddr  <= '0;
      buf_hwrite <= 1'b0;
      buf_htrans <= HTRANS_IDLE;
      buf_hsize  <= 3'd0;
      buf_hprot  <= 4'd0;
    end else if (clr) begin
      full <= 1'b0;
    end else if (load) begin
      full       <= 1'b1;
      buf_haddr  <= haddr;
      buf_hwrite <= hwrite;
      buf_htrans <= htrans;
      buf_hsize  <= hsize;
      buf_hprot  <= hprot;
    end
  end

endmodule

// File: rtl/ahbl_arb_2m.sv
// Two-master AHB5-Lite arbiter: shares one downstream port between the CPU
// data (d) and instruction (i) ports with fixed priority and zero added latency.
module ahbl_arb_2m
  import hazard3_ahb_pkg::*;
#(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [W_ADDR-1:0] d_haddr,
  input  logic              d_hwrite,
  input  logic [1:0]        d_htrans,
  input  logic [2:0]        d_hsize,
  input  logic [3:0]        d_hprot,
  input  logic [W_DATA-1:0] d_hwdata,
  output logic              d_hready,
  output logic              d_hresp,
  output logic [W_DATA-1:0] d_hrdata,

  input  logic [W_ADDR-1:0] i_haddr,
  input  logic              i_hwrite,
  input  logic [1:0]        i_htrans,
  input  logic [2:0]        i_hsize,
  input  logic [3:0]        i_hprot,
  input  logic [W_DATA-1:0] i_hwdata,
  output logic              i_hready,
  output logic              i_hresp,
  output logic [W_DATA-1:0] i_hrdata,

  output logic [W_ADDR-1:0] m_haddr,
  output logic              m_hwrite,
  output logic [1:0]        m_htrans,
  output logic [2:0]        m_hsize,
  output logic [3:0]        m_hprot,
  output logic [W_DATA-1:0] m_hwdata,
  input  logic              m_hready,
  input  logic              m_hresp,
  input  logic [W_DATA-1:0] m_hrdata,

  output logic [1:0]        owner_dbg
);

  // Handshake: an upstream address phase is accepted when htrans[1]=1 and
  // that port's hready=1 in the same cycle; downstream accepts our address
  // phase when m_htrans[1]=1 and m_hready=1. Accepted-but-not-issued
  // requests are parked in the port buffer, which holds the port's hready low.

  owner_t owner;
  owner_t gnt;
  logic   gnt_buf;
  logic   issue;
  logic   d_live, i_live;

  logic              db_full, ib_full;
  logic [W_ADDR-1:0] db_haddr, ib_haddr;
  logic              db_hwrite, ib_hwrite;
  logic [1:0]        db_htrans, ib_htrans;
  logic [2:0]        db_hsize, ib_hsize;
  logic [3:0]        db_hprot, ib_hprot;

  logic [W_ADDR-1:0] a_haddr;
  logic              a_hwrite;
  logic [1:0]        a_htrans;
  logic [2:0]        a_hsize;
  logic [3:0]        a_hprot;

  assign owner_dbg = owner;

  // Upstream responses: hready never depends on htrans, so d_live/i_live
  // below do not form a loop.
  always_comb begin
    d_hready = 1'b1;
    d_hresp  = 1'b0;
    d_hrdata = '0;
    i_hready = 1'b1;
    i_hresp  = 1'b0;
    i_hrdata = '0;
    if (!rst) begin
      if (db_full)
        d_hready = 1'b0;
      else if (owner == OWNER_D)
        d_hready = m_hready;
      if (owner == OWNER_D) begin
        d_hresp  = m_hresp;
        d_hrdata = m_hrdata;
      end
      if (ib_full)
        i_hready = 1'b0;
      else if (owner == OWNER_I)
        i_hready = m_hready;
      if (owner == OWNER_I) begin
        i_hresp  = m_hresp;
        i_hrdata = m_hrdata;
      end
    end
  end

  assign d_live = d_htrans[1] && d_hready;
  assign i_live = i_htrans[1] && i_hready;

  // Fixed priority: buffered d > live d > buffered i > live i.
  always_comb begin
    gnt     = OWNER_IDLE;
    gnt_buf = 1'b0;
    if (db_full) begin
      gnt     = OWNER_D;
      gnt_buf = 1'b1;
    end else if (d_live) begin
      gnt = OWNER_D;
    end else if (ib_full) begin
      gnt     = OWNER_I;
      gnt_buf = 1'b1;
    end else if (i_live) begin
      gnt = OWNER_I;
    end
  end

  always_comb begin
    a_haddr  = d_haddr;
    a_hwrite = d_hwrite;
    a_htrans = d_htrans;
    a_hsize  = d_hsize;
    a_hprot  = d_hprot;
    if (gnt == OWNER_D && gnt_buf) begin
      a_haddr  = db_haddr;
      a_hwrite = db_hwrite;
      a_htrans = db_htrans;
      a_hsize  = db_hsize;
      a_hprot  = db_hprot;
    end else if (gnt == OWNER_I && gnt_buf) begin
      a_haddr  = ib_haddr;
      a_hwrite = ib_hwrite;
      a_htrans = ib_htrans;
      a_hsize  = ib_hsize;
      a_hprot  = ib_hprot;
    end else if (gnt == OWNER_I) begin
      a_haddr  = i_haddr;
      a_hwrite = i_hwrite;
      a_htrans = i_htrans;
      a_hsize  = i_hsize;
      a_hprot  = i_hprot;
    end
  end

  // Address phases are only presented when they will be accepted, so a
  // wait state shows IDLE and a later higher-priority request never has to
  // replace an already-presented transfer.
  assign issue = !rst && m_hready && (gnt != OWNER_IDLE);

  assign m_haddr  = a_haddr;
  assign m_hwrite = a_hwrite;
  assign m_hsize  = a_hsize;
  assign m_hprot  = a_hprot;
  assign m_htrans = issue ? seq_fixup(a_htrans, owner == gnt) : HTRANS_IDLE;
  assign m_hwdata = (owner == OWNER_I) ? i_hwdata : d_hwdata;

  always_ff @(posedge clk) begin
    if (rst)
      owner <= OWNER_IDLE;
    else if (m_hready)
      owner <= issue ? gnt : OWNER_IDLE;
  end

  ahbl_req_buf #(.W_ADDR(W_ADDR)) u_d_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (d_live && !issue),
    .clr        (issue && gnt == OWNER_D && gnt_buf),
    .haddr      (d_haddr),
    .hwrite     (d_hwrite),
    .htrans     (d_htrans),
    .hsize      (d_hsize),
    .hprot      (d_hprot),
    .full       (db_full),
    .buf_haddr  (db_haddr),
    .buf_hwrite (db_hwrite),
    .buf_htrans (db_htrans),
    .buf_hsize  (db_hsize),
    .buf_hprot  (db_hprot)
  );

  ahbl_req_buf #(.W_ADDR(W_ADDR)) u_i_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (i_live && !(issue && gnt == OWNER_I)),
    .clr        (issue && gnt == OWNER_I && gnt_buf),
    .haddr      (i_haddr),
    .hwrite     (i_hwrite),
    .htrans     (i_htrans),
    .hsize      (i_hsize),
    .hprot      (i_hprot),
    .full       (ib_full),
    .buf_haddr  (ib_haddr),
    .buf_hwrite (ib_hwrite),
    .buf_htrans (ib_htrans),
    .buf_hsize  (ib_hsize),
    .buf_hprot  (ib_hprot)
  );

endmodule

// File: tb/tb_ahbl_arb_2m.sv
// Directed bench for the two-master AHB-Lite arbiter: each cycle drives
// upstream/downstream inputs and checks hand-computed outputs mid-cycle.
module tb_ahbl_arb_2m;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic        clk;
  logic        rst;
  logic [31:0] d_haddr, i_haddr, m_haddr;
  logic        d_hwrite, i_hwrite, m_hwrite;
  logic [1:0]  d_htrans, i_htrans, m_htrans;
  logic [2:0]  d_hsize, i_hsize, m_hsize;
  logic [3:0]  d_hprot, i_hprot, m_hprot;
  logic [31:0] d_hwdata, i_hwdata, m_hwdata;
  logic        d_hready, i_hready, m_hready;
  logic        d_hresp, i_hresp, m_hresp;
  logic [31:0] d_hrdata, i_hrdata, m_hrdata;
  logic [1:0]  owner_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  ahbl_arb_2m #(.W_ADDR(32), .W_DATA(32)) dut (
    .clk(clk), .rst(rst),
    .d_haddr(d_haddr), .d_hwrite(d_hwrite), .d_htrans(d_htrans), .d_hsize(d_hsize),
    .d_hprot(d_hprot), .d_hwdata(d_hwdata), .d_hready(d_hready), .d_hresp(d_hresp),
    .d_hrdata(d_hrdata),
    .i_haddr(i_haddr), .i_hwrite(i_hwrite), .i_htrans(i_htrans), .i_hsize(i_hsize),
    .i_hprot(i_hprot), .i_hwdata(i_hwdata), .i_hready(i_hready), .i_hresp(i_hresp),
    .i_hrdata(i_hrdata),
    .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_htrans(m_htrans), .m_hsize(m_hsize),
    .m_hprot(m_hprot), .m_hwdata(m_hwdata), .m_hready(m_hready), .m_hresp(m_hresp),
    .m_hrdata(m_hrdata),
    .owner_dbg(owner_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge, checks
  // happen at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic set_d(input logic [1:0] t, input logic [31:0] a, input logic w);
    d_htrans = t;
    d_haddr  = a;
    d_hwrite = w;
  endtask

  task automatic set_i(input logic [1:0] t, input logic [31:0] a);
    i_htrans = t;
    i_haddr  = a;
  endtask

  task automatic set_m(input logic rdy, input logic resp, input logic [31:0] rdata);
    m_hready = rdy;
    m_hresp  = resp;
    m_hrdata = rdata;
  endtask

  task automatic idle_up();
    set_d(T_IDLE, 32'h0, 1'b0);
    set_i(T_IDLE, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    idle_up();
    d_hsize = 3'd2; i_hsize = 3'd2;
    d_hprot = 4'h3; i_hprot = 4'h2;
    i_hwrite = 1'b0;
    d_hwdata = 32'h0; i_hwdata = 32'h0;
    set_m(1'b1, 1'b1, 32'hFFFF_FFFF);

    // Reset state
    tick(); settle();
    check("rst_m_htrans", {30'd0, m_htrans}, {30'd0, T_IDLE});
    check("rst_d_hready", {31'd0, d_hready}, 32'd1);
    check("rst_i_hready", {31'd0, i_hready}, 32'd1);
    check("rst_d_hresp",  {31'd0, d_hresp}, 32'd0);
    check("rst_d_hrdata", d_hrdata, 32'h0);
    check("rst_i_hrdata", i_hrdata, 32'h0);
    check("rst_owner",    {30'd0, owner_dbg}, 32'd0);
    tick();
    rst = 1'b0;
    set_m(1'b1, 1'b0, 32'h0);

    // Lone d read, forwarded in the same cycle
    set_d(T_NSEQ, 32'h100, 1'b0);
    settle();
    check("lone_haddr",  m_haddr, 32'h100);
    check("lone_htrans", {30'd0, m_htrans}, {30'd0, T_NSEQ});
    check("lone_i_rdy0", {31'd0, i_hready}, 32'd1);
    tick();
    idle_up();
    set_m(1'b1, 1'b0, 32'hDEAD_BEEF);
    settle();
    check("lone_d_rdata", d_hrdata, 32'hDEAD_BEEF);
    check("lone_d_rdy",   {31'd0, d_hready}, 32'd1);
    check("lone_i_rdy1",  {31'd0, i_hready}, 32'd1);
    check("lone_i_rdata", i_hrdata, 32'h0);
    check("lone_owner",   {30'd0, owner_dbg}, 32'd1);
    tick();

    // Simultaneous d write and i fetch
    set_d(T_NSEQ, 32'h200, 1'b1);
    set_i(T_NSEQ, 32'h300);
    set_m(1'b1, 1'b0, 32'h0);
    settle();
    check("sim_haddr0", m_haddr, 32'h200);
    check("sim_hwrite", {31'd0, m_hwrite}, 32'd1);
    check("sim_i_rdy0", {31'd0, i_hready}, 32'd1);
    tick();
    idle_up();
    d_hwdata = 32'h1234_5678;
    settle();
    check("sim_haddr1",  m_haddr, 32'h300);
    check("sim_htrans1", {30'd0, m_htrans}, {30'd0, T_NSEQ});
    check("sim_hwdata",  m_hwdata, 32'h1234_5678);
    check("sim_i_rdy1",  {31'd0, i_hready}, 32'd0);
    tick();
    d_hwdata = 32'h0;
    set_m(1'b1, 1'b0, 32'hCAFE_0300);
    settle();
    check("sim_i_rdy2",  {31'd0, i_hready}, 32'd1);
    check("sim_i_rdata", i_hrdata, 32'hCAFE_0300);
    check("sim_htrans2", {30'd0, m_htrans}, {30'd0, T_IDLE});
    tick();

    // d read stalled 3 cycles while i requests 0x400
    set_d(T_NSEQ, 32'h180, 1'b0);
    set_m(1'b1, 1'b0, 32'h0);
    settle();
    check("stall_haddr0", m_haddr, 32'h180);
    tick();
    idle_up();
    set_i(T_NSEQ, 32'h400);
    set_m(1'b0, 1'b0, 32'h0);
    settle();
    check("stall_d_rdy0",  {31'd0, d_hready}, 32'd0);
    check("stall_i_rdy0",  {31'd0, i_hready}, 32'd1);
    check("stall_htrans0", {30'd0, m_htrans}, {30'd0, T_IDLE});
    tick();
    idle_up();
    for (int k = 1; k < 3; k++) begin
      settle();
      check($sformatf("stall_i_rdy%0d", k), {31'd0, i_hready}, 32'd0);
      check($sformatf("stall_htrans%0d", k), {30'd0, m_htrans}, {30'd0, T_IDLE});
      tick();
    end
    set_m(1'b1, 1'b0, 32'h1111_0180);
    settle();
    check("stall_d_rdata", d_hrdata, 32'h1111_0180);
    check("stall_d_rdy3",  {31'd0, d_hready}, 32'd1);
    check("stall_haddr1",  m_haddr, 32'h400);
    check("stall_htrans3", {30'd0, m_htrans}, {30'd0, T_NSEQ});
    check("stall_i_rdy3",  {31'd0, i_hready}, 32'd0);
    tick();
    set_m(1'b1, 1'b0, 32'h2222_0400);
    settle();
    check("stall_i_rdy4",  {31'd0, i_hready}, 32'd1);
    check("stall_i_rdata", i_hrdata, 32'h2222_0400);
    tick();

    // Error response on d with i buffered
    set_d(T_NSEQ, 32'h500, 1'b0);
    set_i(T_NSEQ, 32'h600);
    set_m(1'b1, 1'b0, 32'h0);
    settle();
    check("err_haddr0", m_haddr, 32'h500);
    tick();
    idle_up();
    set_m(1'b0, 1'b1, 32'h0);
    settle();
    check("err_d_resp0", {31'd0, d_hresp}, 32'd1);
    check("err_d_rdy0",  {31'd0, d_hready}, 32'd0);
    check("err_i_resp0", {31'd0, i_hresp}, 32'd0);
    check("err_i_rdy0",  {31'd0, i_hready}, 32'd0);
    check("err_htrans0", {30'd0, m_htrans}, {30'd0, T_IDLE});
    tick();
    set_m(1'b1, 1'b1, 32'h0);
    settle();
    check("err_d_resp1", {31'd0, d_hresp}, 32'd1);
    check("err_d_rdy1",  {31'd0, d_hready}, 32'd1);
    check("err_i_resp1", {31'd0, i_hresp}, 32'd0);
    check("err_haddr1",  m_haddr, 32'h600);
    check("err_htrans1", {30'd0, m_htrans}, {30'd0, T_NSEQ});
    tick();
    set_m(1'b1, 1'b0, 32'h3333_0600);
    settle();
    check("err_i_rdy2",  {31'd0, i_hready}, 32'd1);
    check("err_i_resp2", {31'd0, i_hresp}, 32'd0);
    check("err_i_rdata", i_hrdata, 32'h3333_0600);
    check("err_d_resp2", {31'd0, d_hresp}, 32'd0);
    tick();

    // i SEQ burst interleaved with a d access
    set_m(1'b1, 1'b0, 32'h0);
    set_i(T_NSEQ, 32'h700);
    settle();
    check("seq_htrans0", {30'd0, m_htrans}, {30'd0, T_NSEQ});
    tick();
    set_i(T_SEQ, 32'h704);
    settle();
    check("seq_htrans1", {30'd0, m_htrans}, {30'd0, T_SEQ});
    tick();
    set_d(T_NSEQ, 32'h800, 1'b0);
    set_i(T_SEQ, 32'h708);
    settle();
    check("seq_haddr2",  m_haddr, 32'h800);
    check("seq_i_rdy2",  {31'd0, i_hready}, 32'd1);
    tick();
    idle_up();
    settle();
    check("seq_haddr3",  m_haddr, 32'h708);
    check("seq_htrans3", {30'd0, m_htrans}, {30'd0, T_NSEQ});
    check("seq_i_rdy3",  {31'd0, i_hready}, 32'd0);
    tick();
    set_i(T_SEQ, 32'h70C);
    settle();
    check("seq_haddr4",  m_haddr, 32'h70C);
    check("seq_htrans4", {30'd0, m_htrans}, {30'd0, T_SEQ});
    tick();
    idle_up();
    settle();
    tick();

    // Reset mid-transfer discards the buffered i request
    set_d(T_NSEQ, 32'h900, 1'b0);
    set_i(T_NSEQ, 32'hA00);
    settle();
    check("mrst_haddr0", m_haddr, 32'h900);
    tick();
    idle_up();
    set_m(1'b0, 1'b0, 32'h5555_5555);
    rst = 1'b1;
    settle();
    check("mrst_htrans1", {30'd0, m_htrans}, {30'd0, T_IDLE});
    check("mrst_d_rdy1",  {31'd0, d_hready}, 32'd1);
    check("mrst_i_rdy1",  {31'd0, i_hready}, 32'd1);
    check("mrst_d_rdata", d_hrdata, 32'h0);
    tick();
    rst = 1'b0;
    set_m(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      settle();
      check($sformatf("mrst_htrans_after%0d", k), {30'd0, m_htrans}, {30'd0, T_IDLE});
      check($sformatf("mrst_owner%0d", k), {30'd0, owner_dbg}, 32'd0);
      check($sformatf("mrst_i_rdy%0d", k), {31'd0, i_hready}, 32'd1);
      check($sformatf("mrst_d_rdy%0d", k), {31'd0, d_hready}, 32'd1);
      tick();
    end

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahbl_arb_2m.md
AHBL_ARB_2M -- requirements
Module: ahbl_arb_2m

Interface
REQ-001 SHALL have parameter W_ADDR, default 32, address width.
REQ-002 SHALL have parameter W_DATA, default 32, data width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have, per upstream port p in {d, i} (d = CPU data port, i = CPU instruction port), inputs p_haddr W_ADDR, p_hwrite 1, p_htrans 2, p_hsize 3, p_hprot 4, p_hwdata W_DATA.
REQ-006 SHALL have, per upstream port, outputs p_hready 1, p_hresp 1, p_hrdata W_DATA.
REQ-007 SHALL have downstream outputs m_haddr, m_hwrite, m_htrans, m_hsize, m_hprot, m_hwdata, with widths as in REQ-005.
REQ-008 SHALL have downstream inputs m_hready 1, m_hresp 1, m_hrdata W_DATA.

Function
REQ-009 SHALL share one AHB5-Lite downstream port between the two upstream masters, so that a dual-port CPU connects to a single-port fabric.
REQ-010 SHALL treat an upstream request as valid when p_htrans[1]=1 and that port's p_hready=1.
REQ-011 SHALL hold one request buffer per port (addr, write, size, prot, trans), loaded when a valid request is not issued downstream in the same cycle.
REQ-012 SHALL use fixed priority: buffered d > live d > buffered i > live i.
REQ-013 SHALL issue the address phase downstream only when m_hready=1; otherwise m_htrans SHALL hold IDLE, or hold the already-presented request unchanged.
REQ-014 SHALL track the data-phase owner in a register with states IDLE, D, I.
- Owner is updated on each m_hready=1 edge from the address phase issued in that cycle.
REQ-015 SHALL route m_hrdata and m_hresp to the owner, and m_hwdata from the owner.
- Non-owner p_hresp=0.
REQ-016 SHALL drive p_hready=1 when the port has no buffered request and is not the data-phase owner.
- When the port is the owner, p_hready SHALL equal m_hready.
- When the port's buffer is full, or its request has been issued but its data phase has not yet started, p_hready SHALL be 0.
REQ-017 SHALL add zero latency to an uncontended request: the address is forwarded in the same cycle.
REQ-018 SHALL add a latency of one address phase per older competing transfer to a contended request.
REQ-019 SHALL forward m_hresp error responses two cycles long (first cycle hready=0, second hready=1) to the owner only.
- A pending buffered request of the other port SHALL be unaffected and issued afterwards.
REQ-020 SHALL downgrade a forwarded SEQ to NONSEQ when the previous downstream address phase came from the other port.
REQ-021 SHALL issue both requests when d and i become valid in the same cycle: d forwarded, i buffered, i issued in the next cycle where m_hready=1.
REQ-022 SHALL never overflow a buffer: no new request is accepted from a port while its p_hready=0.

Reset
REQ-023 SHALL, while rst=1, clear both buffers, set the owner to IDLE, and drive m_htrans=IDLE.
REQ-024 SHALL, while rst=1, drive p_hready=1, p_hresp=0, and p_hrdata=0.
REQ-025 SHALL, when rst is asserted mid-transfer, discard all in-flight and buffered transfers without replay.

Structure
REQ-026 SHALL take the HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ) and the owner-state enum from the shared package hazard3_ahb_pkg.
REQ-027 SHALL contain one sub-module, ahbl_req_buf, instantiated twice: a one-entry request holding register with load/clear/full.
REQ-028 SHALL be 120-400 lines of synthesizable RTL, with no latches and no combinational path from m_hready to m_htrans other than through arbitration.

Verification
REQ-029 Lone d read, 0x0000_0100, m_hready=1, m_hrdata=0xDEAD_BEEF -> m_haddr=0x100 in the same cycle; d_hrdata=0xDEAD_BEEF next cycle; i_hready=1 throughout.
REQ-030 Simultaneous d write 0x200 (wdata 0x1234_5678) and i fetch 0x300 -> downstream 0x200 then 0x300; i_hready low one cycle; m_hwdata=0x1234_5678 in 0x200's data phase.
REQ-031 d read with m_hready=0 for 3 cycles while i requests 0x400 -> i buffered; i_hready=0 until 0x400 completes; m_htrans for 0x400 NONSEQ.
REQ-032 Error on d access 0x500 with i buffered -> d_hresp high for 2 cycles (d_hready 0 then 1); i_hresp=0; i request issued after; completes normally.
REQ-033 Back-to-back i SEQ fetches interleaved with a d access -> first i SEQ after the d access appears downstream as NONSEQ.
REQ-034 rst=1 asserted while i buffered and d in data phase -> next cycle m_htrans=IDLE, both p_hready=1, owner IDLE; no replay after rst=0.
